// File: rtl/grad_tensor_accumulator_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : grad_tensor_accumulator_if                                 |
// | Brief  : sample-in / tensor-sums-out handshake bundle               |
// | Rev    : 1.0  initial release                                       |
// +--------------------------------------------------------------------+
interface grad_tensor_accumulator_if #(
  parameter int p_in_width  = 26,
  parameter int p_sum_width = 2*(p_in_width+1)+10
);
  logic [4:0]             win_dim;
  logic                   in_val;
  logic                   in_rdy;
  logic [p_in_width-1:0]  in_pix;
  logic                   out_val;
  logic                   out_rdy;
  logic [p_sum_width-1:0] out_sxx;
  logic [p_sum_width-1:0] out_sxy;
  logic [p_sum_width-1:0] out_syy;

  modport master (
    output win_dim, in_val, in_pix, out_rdy,
    input  in_rdy, out_val, out_sxx, out_sxy, out_syy
  );

  modport slave (
    input  win_dim, in_val, in_pix, out_rdy,
    output in_rdy, out_val, out_sxx, out_sxy, out_syy
  );
endinterface
`default_nettype wire

// File: rtl/grad_tensor_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : grad_tensor_accumulator                                    |
// | Brief  : accumulates Ix*Ix, Ix*Iy, Iy*Iy over a square pixel window |
// | Rev    : 1.0  initial release                                       |
// +--------------------------------------------------------------------+
module grad_tensor_accumulator #(
  parameter int p_in_width  = 26,
  parameter int p_sum_width = 2*(p_in_width+1)+10
) (
  input  logic                    clk,
  input  logic                    reset,
  grad_tensor_accumulator_if.slave bus
);

  localparam int c_prod_width = 2*(p_in_width+1);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_DONE  = 1'b1
  } state_t;

  state_t                 state_q,   state_d;
  logic                   in_rdy_q,  in_rdy_d;
  logic                   out_val_q, out_val_d;
  logic [4:0]             row_q,     row_d;
  logic [4:0]             col_q,     col_d;
  logic [4:0]             dim_q,     dim_d;
  logic [p_in_width-1:0]  prev_q,    prev_d;
  logic [p_sum_width-1:0] sxx_q,     sxx_d;
  logic [p_sum_width-1:0] sxy_q,     sxy_d;
  logic [p_sum_width-1:0] syy_q,     syy_d;

  logic [p_in_width-1:0]  linebuf_mem [32];

  logic                    accept;
  logic                    first;
  logic [4:0]              eff_dim;
  logic [p_in_width-1:0]   lb_rd;
  logic signed [p_in_width:0]     ix, iy;
  logic signed [c_prod_width-1:0] ix_w, iy_w, pxx, pxy, pyy;

  assign accept  = bus.in_val && in_rdy_q;
  assign first   = (row_q == 5'd0) && (col_q == 5'd0);
  // The first sample of a window must use the live win_dim, since the latch only updates on that edge.
  assign eff_dim = first ? bus.win_dim : dim_q;
  assign lb_rd   = linebuf_mem[col_q];

  assign ix   = $signed({1'b0, bus.in_pix}) - $signed({1'b0, prev_q});
  assign iy   = $signed({1'b0, bus.in_pix}) - $signed({1'b0, lb_rd});
  assign ix_w = c_prod_width'(ix);
  assign iy_w = c_prod_width'(iy);
  assign pxx  = ix_w * ix_w;
  assign pxy  = ix_w * iy_w;
  assign pyy  = iy_w * iy_w;

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    dim_d   = dim_q;
    prev_d  = prev_q;
    sxx_d   = sxx_q;
    sxy_d   = sxy_q;
    syy_d   = syy_q;
    case (state_q)
      ST_ACCUM: begin
        if (accept) begin
          if (first) begin
            dim_d = bus.win_dim;
          end
          prev_d = bus.in_pix;
          if ((row_q != 5'd0) && (col_q != 5'd0)) begin
            sxx_d = sxx_q + p_sum_width'(pxx);
            sxy_d = sxy_q + p_sum_width'(pxy);
            syy_d = syy_q + p_sum_width'(pyy);
          end
          if (col_q == eff_dim) begin
            col_d = 5'd0;
            if (row_q == eff_dim) begin
              row_d   = 5'd0;
              state_d = ST_DONE;
            end else begin
              row_d = row_q + 5'd1;
            end
          end else begin
            col_d = col_q + 5'd1;
          end
        end
      end
      ST_DONE: begin
        if (out_val_q && bus.out_rdy) begin
          state_d = ST_ACCUM;
          row_d   = 5'd0;
          col_d   = 5'd0;
          sxx_d   = '0;
          sxy_d   = '0;
          syy_d   = '0;
        end
      end
      default: state_d = ST_ACCUM;
    endcase
    in_rdy_d  = (state_d == ST_ACCUM);
    out_val_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_ACCUM;
      in_rdy_q  <= 1'b1;
      out_val_q <= 1'b0;
      row_q     <= '0;
      col_q     <= '0;
      dim_q     <= '0;
      prev_q    <= '0;
      sxx_q     <= '0;
      sxy_q     <= '0;
      syy_q     <= '0;
    end else begin
      state_q   <= state_d;
      in_rdy_q  <= in_rdy_d;
      out_val_q <= out_val_d;
      row_q     <= row_d;
      col_q     <= col_d;
      dim_q     <= dim_d;
      prev_q    <= prev_d;
      sxx_q     <= sxx_d;
      sxy_q     <= sxy_d;
      syy_q     <= syy_d;
    end
  end

  // Every entry is written in row 0 before any later row reads it, so no reset is needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      linebuf_mem[col_q] <= bus.in_pix;
    end
  end

  assign bus.in_rdy  = in_rdy_q;
  assign bus.out_val = out_val_q;
  assign bus.out_sxx = sxx_q;
  assign bus.out_sxy = sxy_q;
  assign bus.out_syy = syy_q;

endmodule
`default_nettype wire

// File: tb/tb_grad_tensor_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : tb_grad_tensor_accumulator                                 |
// | Brief  : directed self-checking bench for grad_tensor_accumulator   |
// | Rev    : 1.0  initial release                                       |
// +--------------------------------------------------------------------+
module tb_grad_tensor_accumulator;

  localparam int c_in_w  = 26;
  localparam int c_sum_w = 2*(c_in_w+1)+10;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  grad_tensor_accumulator_if #(.p_in_width(c_in_w), .p_sum_width(c_sum_w)) bif ();

  grad_tensor_accumulator #(.p_in_width(c_in_w), .p_sum_width(c_sum_w)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic push(input logic [c_in_w-1:0] pix);
    int k;
    bif.in_val = 1'b1;
    bif.in_pix = pix;
    k = 0;
    while (!bif.in_rdy && k < 50) begin
      tick();
      k++;
    end
    if (k == 50) check_eq("push_timeout", 64'd1, 64'd0);
    tick();
    bif.in_val = 1'b0;
  endtask

  task automatic handshake();
    bif.out_rdy = 1'b1;
    tick();
    bif.out_rdy = 1'b0;
  endtask

  task automatic expect_sums(input string tag, input logic [63:0] xx,
                             input logic [63:0] xy, input logic [63:0] yy);
    check_eq({tag, "_val"}, 64'(bif.out_val), 64'd1);
    check_eq({tag, "_sxx"}, bif.out_sxx, xx);
    check_eq({tag, "_sxy"}, bif.out_sxy, xy);
    check_eq({tag, "_syy"}, bif.out_syy, yy);
  endtask

  logic [c_in_w-1:0] img [31][31];
  logic [63:0]       neg100;

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    neg100      = -64'sd100;
    reset       = 1'b0;
    bif.win_dim = 5'd0;
    bif.in_val  = 1'b0;
    bif.in_pix  = '0;
    bif.out_rdy = 1'b0;
    do_reset();

    check_eq("rst_in_rdy",  64'(bif.in_rdy), 64'd1);
    check_eq("rst_out_val", 64'(bif.out_val), 64'd0);
    check_eq("rst_sxx", bif.out_sxx, 64'd0);
    check_eq("rst_sxy", bif.out_sxy, 64'd0);
    check_eq("rst_syy", bif.out_syy, 64'd0);

    // 2x2 window, positive gradients
    bif.win_dim = 5'd1;
    push(26'd10); push(26'd20); push(26'd30);
    check_eq("w1_val_early", 64'(bif.out_val), 64'd0);
    push(26'd50);
    expect_sums("w1", 64'd400, 64'd600, 64'd900);
    check_eq("w1_in_rdy_done", 64'(bif.in_rdy), 64'd0);
    handshake();
    check_eq("w1_clr_val", 64'(bif.out_val), 64'd0);
    check_eq("w1_clr_sxx", bif.out_sxx, 64'd0);

    // 3x3 flat window
    bif.win_dim = 5'd2;
    for (int i = 0; i < 8; i++) push(26'd7);
    check_eq("flat_val_8", 64'(bif.out_val), 64'd0);
    push(26'd7);
    expect_sums("flat", 64'd0, 64'd0, 64'd0);
    handshake();

    // single-sample window
    bif.win_dim = 5'd0;
    push(26'd12345);
    expect_sums("dim0", 64'd0, 64'd0, 64'd0);
    handshake();

    // negative cross term, then stall in DONE with in_val held high
    bif.win_dim = 5'd1;
    push(26'd50); push(26'd40); push(26'd20); push(26'd30);
    expect_sums("neg", 64'd100, neg100, 64'd100);
    bif.in_val = 1'b1;
    bif.in_pix = 26'd999;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("stall_in_rdy", 64'(bif.in_rdy), 64'd0);
      check_eq("stall_sxy", bif.out_sxy, neg100);
    end
    expect_sums("stall_end", 64'd100, neg100, 64'd100);
    handshake();
    bif.in_val = 1'b0;
    check_eq("stall_clr_sxx", bif.out_sxx, 64'd0);
    check_eq("stall_clr_syy", bif.out_syy, 64'd0);
    push(26'd10); push(26'd20); push(26'd30); push(26'd50);
    expect_sums("after_stall", 64'd400, 64'd600, 64'd900);
    handshake();

    // reset mid-window discards the partial sums
    push(26'd1); push(26'd2); push(26'd3);
    do_reset();
    check_eq("midrst_in_rdy", 64'(bif.in_rdy), 64'd1);
    check_eq("midrst_val", 64'(bif.out_val), 64'd0);
    push(26'd10); push(26'd20); push(26'd30); push(26'd50);
    expect_sums("midrst", 64'd400, 64'd600, 64'd900);
    handshake();

    // full 31x31 window against a software model, win_dim disturbed mid-window
    begin
      longint mxx, mxy, myy, ix, iy;
      mxx = 0; mxy = 0; myy = 0;
      for (int r = 0; r < 31; r++)
        for (int c = 0; c < 31; c++) begin
          if ((r + c) % 5 == 0)      img[r][c] = {c_in_w{1'b1}};
          else if ((r + c) % 5 == 1) img[r][c] = '0;
          else                       img[r][c] = c_in_w'($urandom);
        end
      for (int r = 1; r < 31; r++)
        for (int c = 1; c < 31; c++) begin
          ix = longint'(img[r][c]) - longint'(img[r][c-1]);
          iy = longint'(img[r][c]) - longint'(img[r-1][c]);
          mxx += ix * ix;
          mxy += ix * iy;
          myy += iy * iy;
        end
      bif.win_dim = 5'd30;
      for (int r = 0; r < 31; r++)
        for (int c = 0; c < 31; c++) begin
          if (r == 0 && c == 1) bif.win_dim = 5'd3;
          if (r == 30 && c == 30)
            check_eq("big_val_early", 64'(bif.out_val), 64'd0);
          push(img[r][c]);
        end
      expect_sums("big", 64'(mxx), 64'(mxy), 64'(myy));
      handshake();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/grad_tensor_accumulator.md
GRAD_TENSOR_ACCUMULATOR -- requirements
Module: grad_tensor_accumulator

Interface
REQ-001 Parameter: p_in_width, 26, width of the unsigned interpolated-pixel input.
REQ-002 Parameter: p_sum_width, 2*(p_in_width+1)+10, width of each tensor sum output.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 win_dim  input  5  last row/column index of the window; the window is (win_dim+1) x (win_dim+1) samples.
REQ-006 in_val  input  1  interpolated-pixel sample valid.
REQ-007 in_rdy  output  1  block can accept a sample.
REQ-008 in_pix  input  p_in_width  interpolated pixel, unsigned, row-major order.
REQ-009 out_val  output  1  tensor sums valid.
REQ-010 out_rdy  input  1  consumer accepts the sums.
REQ-011 out_sxx  output  p_sum_width  sum of Ix*Ix, unsigned.
REQ-012 out_sxy  output  p_sum_width  sum of Ix*Iy, two's complement.
REQ-013 out_syy  output  p_sum_width  sum of Iy*Iy, unsigned.

Function
REQ-014 The FSM SHALL have two states: ACCUM (in_rdy=1, out_val=0) and DONE (in_rdy=0, out_val=1).
REQ-015 A sample SHALL be accepted only on a cycle with in_val && in_rdy.
REQ-016 win_dim SHALL be latched on acceptance of the sample at row 0, col 0; changes at any other time SHALL be ignored until the next window.
REQ-017 Column counter: +1 per accepted sample; wraps to 0 after col == latched win_dim, and row increments on that wrap.
REQ-018 A one-row line buffer (32 entries x p_in_width) SHALL hold the previous row; the entry at index col is read and then overwritten with in_pix on every accept.
REQ-019 A prev-pixel register SHALL hold the last accepted sample of the current row.
REQ-020 For an accepted sample at (r,c) with r>=1 and c>=1: Ix = in_pix - prev, Iy = in_pix - linebuf[c], both signed, p_in_width+1 bits.
REQ-021 For that sample, Ix*Ix, Ix*Iy and Iy*Iy SHALL be added into sxx, sxy and syy at full precision, with sign extension for sxy; samples with r==0 or c==0 SHALL contribute nothing.
REQ-022 Sums SHALL never overflow: the window has at most 31*31 terms, and p_sum_width covers that.
REQ-023 Acceptance of sample (win_dim, win_dim) SHALL move the FSM ACCUM->DONE, with its term included; out_val SHALL rise on the next cycle (latency 1).
REQ-024 In DONE, out_* SHALL hold stable until out_val && out_rdy; on that cycle the FSM SHALL go to ACCUM and the sums and counters SHALL clear to 0.
REQ-025 win_dim==0: the single sample SHALL complete the window, and sums SHALL be 0.
REQ-026 in_val asserted while in DONE SHALL be ignored (not accepted); there is no skid buffering.
REQ-027 out_sxx/sxy/syy SHALL present the live accumulators; they are meaningful only while out_val=1.

Reset
REQ-028 Reset SHALL set the FSM to ACCUM, in_rdy=1, out_val=0, all sums=0, row=col=0, prev=0 and latched win_dim=0.
REQ-029 Line-buffer contents need not be reset; they are always written before being read in any window.
REQ-030 Reset in any state, including mid-window or DONE with a stalled out_rdy, SHALL discard the partial window and the pending result.

Verification
REQ-031 Bench SHALL cover: win_dim=1, samples 10,20,30,50 -> Ix=20, Iy=30; out_sxx=400, out_sxy=600, out_syy=900 one cycle after the 4th accept.
REQ-032 Bench SHALL cover: win_dim=2, all nine samples equal to 7 -> all sums 0, and out_val asserted after exactly 9 accepts.
REQ-033 Bench SHALL cover: win_dim=1, samples 50,40,20,30 -> Ix=10, Iy=-10; out_sxy=-100 (two's complement), out_sxx=out_syy=100.
REQ-034 Bench SHALL cover: DONE with out_rdy=0 for 5 cycles and in_val=1 -> in_rdy=0, no sample consumed, outputs stable; then out_rdy=1 -> next window starts with sums 0.
REQ-035 Bench SHALL cover: reset asserted after 3 samples of a win_dim=1 window -> the next 4 samples form a fresh window with the results of REQ-031.
REQ-036 Bench SHALL cover: win_dim=30 with random pixels, including max-valued in_pix (2^26-1 next to 0) -> sums match a software model with no overflow; win_dim changed mid-window has no effect.
